alu_share_arbiter: RTL and testbench

- Shares one combinational integer ALU between two requesters; one operation in flight at a time.
- Round-robin grant, registered operand launch, registered result with a valid/ready response channel.
- Sits between the instruction front-ends (requester 0/1) and the ALU datapath built from the gate-level primitives; it sequences the ALU and does no arithmetic itself.

---
 rtl/alu_share_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational integer ALU between two requesters. Only one
// operation is ever in flight: a request is granted in IDLE, its operands are
// registered onto the ALU inputs, the ALU result is captured one cycle later,
// and the captured result is held on a valid/ready response channel until the
// consumer takes it. Arbitration between simultaneous requesters is
// round-robin on the index of the last accepted requester.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req{0,1}_valid/_ready         request handshake per requester
//   req{0,1}_op/_a/_b             request opcode and operands
//   alu_op, alu_a, alu_b          registered launch to the shared ALU
//   alu_y, alu_carry              combinational ALU result / carry-out
//   rsp_valid, rsp_ready          response handshake
//   rsp_id                        requester index owning the response
//   rsp_y, rsp_carry              captured ALU result and carry
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_carry
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic             last_grant_r;
  logic             grant_id_r;
  logic             grant_s;
  logic             any_valid_s;
  logic             accept_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             handshake_s;

  logic [OPW-1:0]   sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  logic [OPW-1:0]   alu_op_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_y_r;
  logic             rsp_carry_r;

  assign any_valid_s = req0_valid | req1_valid;
  assign handshake_s = rsp_valid_r & rsp_ready;

  // Round-robin grant: a lone requester wins outright; on contention the
  // requester that was not served last time wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Operand mux feeding the launch registers from the granted requester.
  always_comb begin
    sel_op_s = req0_op;
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    if (grant_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: IDLE waits for any request, EXEC lasts exactly one
  // cycle, RESP waits for the response handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (handshake_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: the readies are only ever high in IDLE, and only for the
  // granted requester. They are also held low while reset is asserted so a
  // requester cannot see a spurious accept during reset.
  always_comb begin
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    accept_s = 1'b0;
    if ((state_r == ST_IDLE) && any_valid_s && rst_n) begin
      accept_s = 1'b1;
      if (grant_s) begin
        ready1_s = 1'b1;
      end else begin
        ready0_s = 1'b1;
      end
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
      accept_s = 1'b0;
    end
  end

  // Launch registers: operands are captured on acceptance and then held,
  // including after the operation completes (they are never cleared).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_r     <= {OPW{1'b0}};
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      grant_id_r   <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      alu_op_r     <= sel_op_s;
      alu_a_r      <= sel_a_s;
      alu_b_r      <= sel_b_s;
      grant_id_r   <= grant_s;
      last_grant_r <= grant_s;
    end
  end

  // Response registers: the ALU result is sampled at the end of EXEC and
  // held until the consumer accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_y_r     <= {WIDTH{1'b0}};
      rsp_carry_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= grant_id_r;
      rsp_y_r     <= alu_y;
      rsp_carry_r <= alu_carry;
    end else if ((state_r == ST_RESP) && handshake_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign alu_op     = alu_op_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_y      = rsp_y_r;
  assign rsp_carry  = rsp_carry_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. A small ALU model closes the
// loop on alu_y/alu_carry. A transaction-level model (one operation in
// flight, tracked by its age in cycles since acceptance) predicts every
// output each cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W = 8;
  localparam int O = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [O-1:0] req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [O-1:0] req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic [O-1:0] alu_op;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         alu_carry;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [W-1:0] rsp_y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .OPW(O)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_carry(rsp_carry)
  );

  // Reference ALU: op0 ADD, op1 SUB (borrow in carry), op2 AND, op3 OR,
  // op4 XOR, anything else passes a through.
  function automatic logic [W:0] alu_fn(input logic [O-1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_carry, alu_y} = alu_fn(alu_op, alu_a, alu_b);

  // ---------------- transaction-level model ----------------
  bit           m_inflight;
  int           m_age;
  bit           m_last;
  bit           m_id;
  logic [O-1:0] m_op;
  logic [W-1:0] m_a, m_b, m_y;
  bit           m_c;
  int           acc_cyc[$];
  bit           acc_id[$];

  task automatic model_reset();
    m_inflight = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
    m_op = '0; m_a = '0; m_b = '0; m_y = '0; m_c = 1'b0;
  endtask

  function automatic bit model_grant();
    if (req0_valid && req1_valid) return ~m_last;
    return req1_valid;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    bit any, g, vis;
    any = req0_valid | req1_valid;
    g   = model_grant();
    vis = m_inflight && (m_age >= 1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, !m_inflight && any && !g});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, !m_inflight && any && g});
    chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
    chk("alu_a", {24'd0, alu_a}, {24'd0, m_a});
    chk("alu_b", {24'd0, alu_b}, {24'd0, m_b});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, vis});
    if (vis) begin
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      chk("rsp_y", {24'd0, rsp_y}, {24'd0, m_y});
      chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, m_c});
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_step();
    bit g;
    if (!m_inflight) begin
      if (req0_valid || req1_valid) begin
        g = model_grant();
        m_inflight = 1'b1; m_age = 0;
        m_op = g ? req1_op : req0_op;
        m_a  = g ? req1_a  : req0_a;
        m_b  = g ? req1_b  : req0_b;
        m_last = g; m_id = g;
        acc_cyc.push_back(cyc); acc_id.push_back(g);
      end
    end else if (m_age >= 1 && rsp_ready) begin
      m_inflight = 1'b0;
    end else begin
      m_age++;
      if (m_age == 1) {m_c, m_y} = alu_fn(m_op, m_a, m_b);
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model, return
  // just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int n, input bit v, input logic [O-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
    chk({nm, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
    chk({nm, "_alu"}, {21'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk({nm, "_rsp"}, {22'd0, rsp_valid, rsp_id, rsp_carry, rsp_y}, 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string nm);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero(nm);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    logic [W-1:0] y0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request: ADD 05+03 from requester 0.
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 8'h05, 8'h03);
    #2;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    #2;
    chk("t1_exec_ready0", {31'd0, req0_ready}, 32'd0);
    chk("t1_alu_a", {24'd0, alu_a}, 32'h05);
    chk("t1_alu_b", {24'd0, alu_b}, 32'h03);
    tick();
    #2;
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_y", {24'd0, rsp_y}, 32'h08);
    chk("t1_rsp_carry", {31'd0, rsp_carry}, 32'd0);
    chk("t1_rsp_id", {31'd0, rsp_id}, 32'd0);
    tick();
    #2;
    chk("t1_rsp_done", {31'd0, rsp_valid}, 32'd0);

    // Carry out: FF+01 from requester 1.
    set_req(1, 1'b1, 3'd0, 8'hFF, 8'h01);
    tick();
    req1_valid = 1'b0;
    tick();
    #2;
    chk("t2_rsp_y", {24'd0, rsp_y}, 32'h00);
    chk("t2_rsp_carry", {31'd0, rsp_carry}, 32'd1);
    chk("t2_rsp_id", {31'd0, rsp_id}, 32'd1);
    tick();

    // Contention: both valid, rsp_ready high -> 0,1,0,1 three cycles apart.
    n0 = acc_id.size();
    set_req(0, 1'b1, 3'd2, 8'hF0, 8'h3C);
    set_req(1, 1'b1, 3'd4, 8'hAA, 8'h0F);
    repeat (12) tick();
    drain();
    chk("t3_count", acc_id.size() - n0, 32'd4);
    if (acc_id.size() >= n0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t3_order", {31'd0, acc_id[n0+k]}, k % 2);
        if (k > 0) chk("t3_interval", acc_cyc[n0+k] - acc_cyc[n0+k-1], 32'd3);
      end
    end

    // Backpressure: hold the response 5 cycles with both requesters waiting.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'd1, 8'h10, 8'h03);
    tick();
    req0_valid = 1'b0;
    tick();
    #2;
    y0 = rsp_y;
    chk("t4_rsp_y", {24'd0, y0}, 32'h0D);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (5) tick();
    #2;
    chk("t4_hold_y", {24'd0, rsp_y}, 32'h0D);
    chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    #2;
    chk("t4_next_grant1", {31'd0, req1_ready}, 32'd1);
    tick();
    drain();

    // Async reset during EXEC, then first grant goes to requester 0.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    async_reset("t5_rst");
    n0 = acc_id.size();
    tick();
    chk("t5_accepted", acc_id.size() - n0, 32'd1);
    chk("t5_first_grant", {31'd0, acc_id[acc_id.size()-1]}, 32'd0);
    drain();

    // Fairness: requester 1 alone for three operations, then both valid.
    n0 = acc_id.size();
    set_req(0, 1'b0, 3'd3, 8'h01, 8'h02);
    set_req(1, 1'b1, 3'd0, 8'h40, 8'h41);
    repeat (9) tick();
    req0_valid = 1'b1;
    tick();
    chk("t6_count", acc_id.size() - n0, 32'd4);
    if (acc_id.size() >= n0 + 4) begin
      for (int k = 0; k < 3; k++) chk("t6_req1_only", {31'd0, acc_id[n0+k]}, 32'd1);
      chk("t6_req0_next", {31'd0, acc_id[n0+3]}, 32'd0);
    end
    drain();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      set_req(0, ($urandom_range(0, 99) < 45), O'($urandom_range(0, 7)),
              W'($urandom), W'($urandom));
      set_req(1, ($urandom_range(0, 99) < 45), O'($urandom_range(0, 7)),
              W'($urandom), W'($urandom));
      rsp_ready = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
